ribbon_adc_responder: RTL

Device-side SPI responder that emulates the ribbon sensor's 8-channel, 10-bit ADC. It lets `ribbon_decoder` and the rest of the ribbon datapath run in simulation and hardware-in-loop without the physical converter. It decodes the 5-bit command, drives a null bit, then drives 10 data bits MSB-first from an internal 8-entry sample bank that the test/host logic loads.

---
 rtl/ribbon_adc_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ribbon_adc_responder.sv
// SPI responder emulating the ribbon sensor's 8-channel, 10-bit ADC.
// Decodes start/SGL/D2..D0, drives a null bit, then 10 sample bits MSB-first.
module ribbon_adc_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [9:0] wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [2:0] last_ch,
  output logic       last_sgl
);

  localparam int unsigned DW  = 10;
  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CMD,
    S_NULL,
    S_DATA,
    S_TAIL
  } state_t;

  state_t          state;
  logic [1:0]      sclk_sync;
  logic [1:0]      cs_sync;
  logic [1:0]      mosi_sync;
  logic            sclk_d;
  logic [1:0]      settle;
  logic            armed;
  logic [CW-1:0]   cnt;
  logic [2:0]      cmd;
  logic [DW-1:0]   shreg;
  logic [DW-1:0]   bank [NCH];
  logic            rise_c;
  logic            fall_c;
  logic            cs_c;
  logic            mosi_c;

  assign cs_c   = cs_sync[1];
  assign mosi_c = mosi_sync[1];
  assign rise_c = sclk_sync[1] & ~sclk_d;
  assign fall_c = ~sclk_sync[1] & sclk_d;

  // Two-flop synchronizers plus the sclk edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  // After reset, only a cs_n low seen after a settled high may start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && cs_c) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) bank[i] <= '0;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

  // Frame state machine; a cs_n release beats any same-cycle sclk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      miso       <= 1'b1;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      last_ch    <= '0;
      last_sgl   <= 1'b0;
      cnt        <= '0;
      cmd        <= '0;
      shreg      <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (cs_c) begin
        state <= S_IDLE;
        miso  <= 1'b1;
        cnt   <= '0;
        if (state == S_CMD || state == S_NULL || state == S_DATA) frame_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            miso <= 1'b1;
            cnt  <= '0;
            if (armed) state <= S_WAIT;
          end
          S_WAIT: begin
            miso <= 1'b1;
            cnt  <= '0;
            if (rise_c && mosi_c) state <= S_CMD;
          end
          S_CMD: begin
            miso <= 1'b1;
            if (rise_c) begin
              cmd <= {cmd[1:0], mosi_c};
              cnt <= cnt + CW'(1);
              if (cnt == CW'(3)) begin
                last_sgl <= cmd[2];
                last_ch  <= {cmd[1:0], mosi_c};
                state    <= S_NULL;
              end
            end
          end
          S_NULL: begin
            if (fall_c) begin
              miso  <= 1'b0;
              shreg <= last_sgl ? bank[last_ch] : '0;
              cnt   <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (fall_c) begin
              miso  <= shreg[DW-1];
              shreg <= {shreg[DW-2:0], 1'b0};
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(DW - 1)) begin
                frame_done <= 1'b1;
                state      <= S_TAIL;
              end
            end
          end
          S_TAIL: begin
            if (fall_c) miso <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            miso  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
